// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding,
// flag bit positions and the latched request record.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // rsp_flags = {V, eq, lt, Cout}
  localparam int FLAG_COUT = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_EQ   = 2;
  localparam int FLAG_V    = 3;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the arbiter.
interface alu_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0;
  logic [2:0]  req_op1;
  logic [15:0] req_x0;
  logic [15:0] req_x1;
  logic [15:0] req_y0;
  logic [15:0] req_y1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_op0, req_op1, req_x0, req_x1, req_y0, req_y1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_x0, req_x1, req_y0, req_y1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Team 16-bit combinational ALU. eq/lt always come from the subtract path;
// lt is the unsigned compare (borrow), Cout follows the x + ~y + 1 convention.
module ALU
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        eq,
  output logic        lt
);

  logic [16:0] add_sum;
  logic [16:0] sub_sum;
  logic        add_ovf;
  logic        sub_ovf;

  assign add_sum = {1'b0, x} + {1'b0, y};
  assign sub_sum = {1'b0, x} + {1'b0, ~y} + 17'd1;

  assign add_ovf = (x[15] == y[15]) && (add_sum[15] != x[15]);
  assign sub_ovf = (x[15] != y[15]) && (sub_sum[15] != x[15]);

  assign eq = (sub_sum[15:0] == 16'h0000);
  assign lt = ~sub_sum[16];

  // Carry/overflow are raw here; the arbiter decides when they are meaningful.
  assign cout = (op == OP_ADD) ? add_sum[16] : sub_sum[16];
  assign ovf  = (op == OP_ADD) ? add_ovf : sub_ovf;

  always_comb begin
    result = 16'h0000;
    case (op)
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_ADD:  result = add_sum[15:0];
      OP_SUB:  result = sub_sum[15:0];
      OP_SLT:  result = {16{lt}};
      default: result = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared ALU:
// IDLE grants a request, EXEC computes and registers, RESP holds until taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  alu_req_t    req_q, req_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;

  alu_req_t    req0;
  alu_req_t    req1;
  logic [1:0]  grant;
  logic        op_legal;
  logic        op_arith;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_eq;
  logic        alu_lt;
  logic [3:0]  flags_calc;

  assign req0.op = bus.req_op0;
  assign req0.x  = bus.req_x0;
  assign req0.y  = bus.req_y0;
  assign req1.op = bus.req_op1;
  assign req1.x  = bus.req_x1;
  assign req1.y  = bus.req_y1;

  always_comb begin
    grant = 2'b00;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  ALU u_alu (
    .op     (req_q.op),
    .x      (req_q.x),
    .y      (req_q.y),
    .result (alu_result),
    .cout   (alu_cout),
    .ovf    (alu_ovf),
    .eq     (alu_eq),
    .lt     (alu_lt)
  );

  always_comb begin
    op_legal = 1'b0;
    case (req_q.op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  assign op_arith = (req_q.op == OP_ADD) || (req_q.op == OP_SUB);

  always_comb begin
    flags_calc            = 4'h0;
    flags_calc[FLAG_EQ]   = alu_eq;
    flags_calc[FLAG_LT]   = alu_lt;
    flags_calc[FLAG_COUT] = op_arith & alu_cout;
    flags_calc[FLAG_V]    = op_arith & alu_ovf;
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    req_d   = req_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          req_d   = grant[1] ? req1 : req0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = op_legal ? alu_result : 16'h0000;
        flags_d = op_legal ? flags_calc : 4'h0;
        err_d   = ~op_legal;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's rsp_ready completes the transfer.
        if (bus.rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prio_q  <= (RR_INIT != 0);
      owner_q <= 1'b0;
      req_q   <= '0;
      data_q  <= 16'h0000;
      flags_q <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE && reset_n) ? grant : 2'b00;
  assign bus.rsp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the driver pushes expected responses at grant
// time, a separate monitor pops and compares them when rsp_valid appears.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic        port;
    logic [15:0] data;
    logic [3:0]  flags;
    logic        err;
    int          acc;
    int          hold;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  logic prio_m;
  exp_t q[$];

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic [3:0] f, input logic e, input int h);
    exp_t r;
    r.port  = 1'b0;
    r.data  = d;
    r.flags = f;
    r.err   = e;
    r.acc   = 0;
    r.hold  = h;
    return r;
  endfunction

  // Called right at a negedge; returns at the negedge after the grant.
  task automatic issue(input logic [1:0] v,
                       input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1,
                       input exp_t e0, input exp_t e1, input bit push, input bit keep,
                       output int gcyc);
    bit   got;
    logic pred;
    exp_t e;
    got  = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge clk);
      bus.req_valid = v;
      bus.req_op0 = o0; bus.req_x0 = a0; bus.req_y0 = b0;
      bus.req_op1 = o1; bus.req_x1 = a1; bus.req_y1 = b1;
      #1;
      if (bus.req_ready != 2'b00) begin
        got  = 1'b1;
        gcyc = cyc;
        pred = (v == 2'b11) ? prio_m : v[1];
        chk("grant", {30'd0, bus.req_ready}, pred ? 32'd2 : 32'd1);
        if (push) begin
          e      = pred ? e1 : e0;
          e.port = pred;
          e.acc  = cyc;
          q.push_back(e);
        end
      end
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!keep) bus.req_valid = 2'b00;
  endtask

  // Monitor: compares every response cycle against the queue head.
  initial begin
    bit   in_resp;
    int   vcnt;
    exp_t h;
    in_resp = 1'b0;
    vcnt    = 0;
    prio_m  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        q.delete();
        in_resp = 1'b0;
        prio_m  = 1'b0;
      end else if (bus.rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", {30'd0, bus.rsp_valid}, 32'd0);
        end else begin
          h = q[0];
          if (!in_resp) begin
            chk("latency", cyc, h.acc + 2);
            in_resp = 1'b1;
            vcnt    = 0;
          end
          vcnt++;
          chk("rsp_valid", {30'd0, bus.rsp_valid}, h.port ? 32'd2 : 32'd1);
          chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, h.data});
          chk("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, h.flags});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, h.err});
          chk("req_ready_in_resp", {30'd0, bus.req_ready}, 32'd0);
          chk("busy_in_resp", {31'd0, bus.busy}, 32'd1);
          if (bus.rsp_ready[h.port]) begin
            chk("hold_cycles", vcnt, h.hold);
            $display("rsp port=%0d data=%h flags=%b err=%b cycle=%0d",
                     h.port, bus.rsp_data, bus.rsp_flags, bus.rsp_err, cyc);
            void'(q.pop_front());
            prio_m  = ~h.port;
            in_resp = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    int   c0;
    exp_t nx;
    n_cmp  = 0;
    n_fail = 0;
    nx     = mk(16'h0, 4'h0, 1'b0, 1);
    reset_n       = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    bus.req_op0 = OP_SUB; bus.req_x0 = 16'd5; bus.req_y0 = 16'd5;
    bus.req_op1 = OP_SLT; bus.req_x1 = 16'd3; bus.req_y1 = 16'd7;

    // Reset state, with both requesters already valid.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_rsp_flags", {28'd0, bus.rsp_flags}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);

    // Both valid from reset: grants 0,1,0,1; first grant in the release cycle.
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    issue(2'b11, OP_SUB, 16'd5, 16'd5, OP_SLT, 16'd3, 16'd7,
          mk(16'h0000, 4'b0101, 1'b0, 1), mk(16'hFFFF, 4'b0010, 1'b0, 1), 1'b1, 1'b1, g);
    chk("first_grant_cycle", g, c0);
    for (int i = 0; i < 3; i++)
      issue(2'b11, OP_SUB, 16'd5, 16'd5, OP_SLT, 16'd3, 16'd7,
            mk(16'h0000, 4'b0101, 1'b0, 1), mk(16'hFFFF, 4'b0010, 1'b0, 1), 1'b1, i < 2, g);

    // Port 0 ADD 0x7FFF + 1: signed overflow, no carry.
    issue(2'b01, OP_ADD, 16'h7FFF, 16'h0001, OP_AND, 16'h0, 16'h0,
          mk(16'h8000, 4'b1000, 1'b0, 1), nx, 1'b1, 1'b0, g);

    // Port 0 illegal opcode 4.
    issue(2'b01, 3'd4, 16'h1111, 16'h2222, OP_AND, 16'h0, 16'h0,
          mk(16'h0000, 4'b0000, 1'b1, 1), nx, 1'b1, 1'b0, g);

    // Port 1 AND stalled 4 cycles; port 0 ready and pending request must not intrude.
    issue(2'b10, OP_AND, 16'h0, 16'h0, OP_AND, 16'hF0F0, 16'h0FF0,
          nx, mk(16'h00F0, 4'b0000, 1'b0, 5), 1'b1, 1'b0, g);
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b01;
    bus.req_op0 = OP_SUB; bus.req_x0 = 16'h0000; bus.req_y0 = 16'h0001;
    repeat (5) @(negedge clk);
    bus.rsp_ready = 2'b11;

    // Port 0 SUB 0 - 1: borrow, so Cout=0 and lt=1.
    issue(2'b01, OP_SUB, 16'h0000, 16'h0001, OP_AND, 16'h0, 16'h0,
          mk(16'hFFFF, 4'b0010, 1'b0, 1), nx, 1'b1, 1'b0, g);

    // Port 0 OR abandoned by reset during EXEC; priority was 1 beforehand.
    issue(2'b01, OP_OR, 16'h1234, 16'h4321, OP_AND, 16'h0, 16'h0,
          nx, nx, 1'b0, 1'b0, g);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("midrst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("midrst_rsp_flags", {28'd0, bus.rsp_flags}, 32'd0);
    chk("midrst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Priority back at RR_INIT: port 0 first, then port 1.
    issue(2'b11, OP_ADD, 16'd1, 16'd2, OP_OR, 16'hFF00, 16'h00FF,
          mk(16'h0003, 4'b0010, 1'b0, 1), mk(16'hFFFF, 4'b0000, 1'b0, 1), 1'b1, 1'b1, g);
    issue(2'b11, OP_ADD, 16'd1, 16'd2, OP_OR, 16'hFF00, 16'h00FF,
          mk(16'h0003, 4'b0010, 1'b0, 1), mk(16'hFFFF, 4'b0000, 1'b0, 1), 1'b1, 1'b0, g);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: arbiter accepts requester i this cycle; at most one bit high.
REQ-006 req_op0 / req_op1  input  3 each  opcode of requester 0 / 1.
REQ-007 req_x0 / req_x1  input  16 each  operand X of requester 0 / 1.
REQ-008 req_y0 / req_y1  input  16 each  operand Y of requester 0 / 1.
REQ-009 rsp_valid  output  2  bit i: result for requester i available; at most one bit high.
REQ-010 rsp_ready  input  2  bit i: requester i takes the result.
REQ-011 rsp_data  output  16  registered ALU result, shared by both requesters.
REQ-012 rsp_flags  output  4  registered {V, eq, lt, Cout}.
REQ-013 rsp_err  output  1  high with rsp_valid when the opcode was illegal.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Three-state FSM: IDLE, EXEC, RESP.
REQ-016 IDLE: if no req_valid bit is set, remain in IDLE with req_ready=0.
REQ-017 IDLE: if exactly one req_valid bit is set, assert that port's req_ready combinationally, latch its op/x/y and owner index, and go to EXEC.
REQ-018 IDLE: if both req_valid bits are set, grant the port holding priority.
REQ-019 EXEC: drive the shared ALU from the latched operands, register result and flags at the end of the cycle, then go to RESP.
REQ-020 RESP: assert rsp_valid[owner] and hold rsp_data/rsp_flags/rsp_err stable until rsp_ready[owner]=1.
REQ-021 On the rsp_ready handshake, return to IDLE and give priority to the non-owner port.
REQ-022 rsp_ready on the non-owner port is ignored.
REQ-023 Latency: acceptance in cycle N gives rsp_valid in cycle N+2.
REQ-024 Minimum issue interval is 3 cycles; no new grant while busy=1.
REQ-025 Legal opcodes are 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (all-ones if X<Y, else 0).
REQ-026 Illegal opcodes (3, 4, 5) return rsp_data=0x0000, rsp_flags=0 and rsp_err=1 with the same timing as a legal operation.
REQ-027 Arithmetic is 16-bit wrap-around.
REQ-028 Cout and V are meaningful only for ADD and SUB and are reported as 0 for all other opcodes.
REQ-029 lt and eq are reported as produced by the subtract path for every legal opcode.
REQ-030 req_valid may drop without a grant; no request is retained across cycles.
REQ-031 Requester inputs are sampled only in the cycle of acceptance.

Reset
REQ-032 While reset_n=0 at a clk edge: state=IDLE, priority=RR_INIT, req_ready=0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, busy=0.
REQ-033 Reset asserted in EXEC or RESP abandons the in-flight operation; no rsp_valid appears after reset release.
REQ-034 The first grant after reset release may occur in the first cycle reset_n=1.

Structure
REQ-035 A shared package holds the opcode constants (OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7), the FSM state encoding, and the flag bit positions.
REQ-036 Exactly one sub-module: the team's 16-bit ALU (module ALU), instantiated once.
REQ-037 Opcode legality checking, arbitration and flag masking are implemented in alu_arbiter.

Verification
REQ-038 Port 0 ADD x=0x7FFF, y=0x0001, rsp_ready held 1 -> rsp_valid[0] 2 cycles after accept, rsp_data=0x8000, V=1, Cout=0, rsp_err=0.
REQ-039 Both ports valid from reset with RR_INIT=0: port 0 SUB 5-5, port 1 SLT 3,7 -> port 0 served first (0x0000, eq=1), then port 1 (0xFFFF, lt=1); grants alternate 0,1,0,1 while both stay valid.
REQ-040 Port 1 AND 0xF0F0,0x0FF0 with rsp_ready=0 for 4 cycles -> rsp_valid[1] and rsp_data=0x00F0 held for 4 cycles; req_ready stays 0 during the stall.
REQ-041 Port 0 opcode 4 -> rsp_data=0x0000, rsp_flags=0, rsp_err=1, latency 2.
REQ-042 reset_n=0 during EXEC of port 0 OR 0x1234,0x4321 -> all outputs 0 next cycle; no rsp_valid afterwards; priority = RR_INIT.
REQ-043 SUB 0x0000-0x0001 -> rsp_data=0xFFFF, lt=1, eq=0, Cout consistent with the ALU borrow convention.
